output_buffer_tx: RTL and testbench

//  Per-output-port buffer and link transmitter; one instance per router output port k.

---
 rtl/output_buffer_tx_pkg.sv | 13 +
 rtl/output_buffer_tx_fifo.sv | 75 +++++++
 rtl/output_buffer_tx.sv | 125 ++++++++++++
 tb/tb_output_buffer_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/output_buffer_tx_pkg.sv
// Shared router types: packet word, link framing and transmit FSM states.
package RouterPkg;

    typedef logic [31:0] pkt_t;

    localparam int unsigned BYTES_PER_PKT = 4;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_t;

endpackage

// File: rtl/output_buffer_tx_fifo.sv
// Synchronous packet FIFO with a combinational head output.
// Pointers wrap modulo DEPTH, so DEPTH does not need to be a power of two.
module pkt_fifo
    import RouterPkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = pkt_t
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  T                           din,
    output T                           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; requests are guarded internally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the queue.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Packet storage; contents are don't-care while the queue is empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/output_buffer_tx.sv
// Per-output-port packet buffer and byte-serial link transmitter (MSB byte first).
module output_buffer_tx
    import RouterPkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ROUTERID = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  pkt_t                       pkt_in,
    input  logic                       pkt_in_avail,
    output logic                       ob_ready_to_recv,
    input  logic                       free_outbound,
    output logic                       put_outbound,
    output logic [7:0]                 payload_outbound,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow_err
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PKT - 1);

    pkt_t      fifo_head;
    logic      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic      start_ok;

    tx_state_t state_q, state_d;
    logic [1:0] byte_cnt_q, byte_cnt_d;
    pkt_t      shreg_q, shreg_d;
    logic      put_q, put_d;
    logic [7:0] payload_q, payload_d;
    logic      overflow_q, overflow_d;

    pkt_fifo #(
        .DEPTH (DEPTH),
        .T     (pkt_t)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (pkt_in),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ob_ready_to_recv = !fifo_full;
    assign put_outbound     = put_q;
    assign payload_outbound = payload_q;
    assign overflow_err     = overflow_q;

    // Accept / drop decision; ready depends on the count alone, never on a same-cycle pop.
    always_comb begin
        fifo_push  = pkt_in_avail && ob_ready_to_recv;
        overflow_d = overflow_q || (pkt_in_avail && !ob_ready_to_recv);
    end

    // Transmit FSM. The link byte is registered, so the first byte is loaded
    // straight from the FIFO head and the shift register holds the remaining bytes.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        put_d      = 1'b0;
        payload_d  = '0;
        fifo_pop   = 1'b0;
        start_ok   = !fifo_empty && free_outbound;
        case (state_q)
            TX_IDLE: begin
                if (start_ok) begin
                    fifo_pop   = 1'b1;
                    state_d    = TX_SEND;
                    byte_cnt_d = '0;
                    shreg_d    = {fifo_head[23:0], 8'h00};
                    put_d      = 1'b1;
                    payload_d  = fifo_head[31:24];
                end
            end
            TX_SEND: begin
                if (byte_cnt_q == LAST_BYTE) begin
                    if (start_ok) begin
                        fifo_pop   = 1'b1;
                        byte_cnt_d = '0;
                        shreg_d    = {fifo_head[23:0], 8'h00};
                        put_d      = 1'b1;
                        payload_d  = fifo_head[31:24];
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    put_d      = 1'b1;
                    payload_d  = shreg_q[31:24];
                    shreg_d    = {shreg_q[23:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // State, link output and sticky error registers; reset aborts any packet in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
            put_q      <= 1'b0;
            payload_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            put_q      <= put_d;
            payload_q  <= payload_d;
            overflow_q <= overflow_d;
        end
    end

    // The FSM must only pop when a packet is queued.
    a_pop_nonempty : assert property (@(posedge clock) disable iff (reset) fifo_pop |-> !fifo_empty)
        else $error("output_buffer_tx[%0d]: pop from empty FIFO", ROUTERID);

endmodule

// File: tb/tb_output_buffer_tx.sv
// Scoreboard bench for output_buffer_tx: accepted packets queue their bytes,
// the link monitor pops and compares every byte the DUT puts on the link.
module tb_output_buffer_tx;
    import RouterPkg::*;

    localparam int DEPTH = 4;

    logic                       clock = 1'b0;
    logic                       reset;
    pkt_t                       pkt_in;
    logic                       pkt_in_avail;
    logic                       ob_ready_to_recv;
    logic                       free_outbound;
    logic                       put_outbound;
    logic [7:0]                 payload_outbound;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic                       overflow_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];
    bit         mon_en   = 1'b0;

    output_buffer_tx #(
        .DEPTH    (DEPTH),
        .ROUTERID (3)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .pkt_in           (pkt_in),
        .pkt_in_avail     (pkt_in_avail),
        .ob_ready_to_recv (ob_ready_to_recv),
        .free_outbound    (free_outbound),
        .put_outbound     (put_outbound),
        .payload_outbound (payload_outbound),
        .fifo_count       (fifo_count),
        .overflow_err     (overflow_err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Link monitor: every put byte must match the scoreboard head; idle link must be 0.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            if (put_outbound) begin
                if (sb.size() == 0) check_eq("unexpected_put", {31'b0, put_outbound}, 32'd0);
                else                check_eq("link_byte", {24'b0, payload_outbound}, {24'b0, sb.pop_front()});
            end else begin
                check_eq("idle_payload", {24'b0, payload_outbound}, 32'd0);
            end
        end
    end

    task automatic sb_add(input pkt_t d);
        sb.push_back(d[31:24]);
        sb.push_back(d[23:16]);
        sb.push_back(d[15:8]);
        sb.push_back(d[7:0]);
    endtask

    task automatic push_pkt(input pkt_t d, input bit acc);
        @(posedge clock); #1;
        pkt_in       = d;
        pkt_in_avail = 1'b1;
        if (acc) sb_add(d);
        @(posedge clock); #1;
        pkt_in_avail = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_put();
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clock);
            seen = put_outbound;
        end
        check_eq("put_seen", {31'b0, seen}, 32'd1);
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            done = (sb.size() == 0) && !put_outbound;
        end
        check_eq("drain_left", sb.size(), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_put"},     {31'b0, put_outbound}, 32'd0);
        check_eq({tag, "_payload"}, {24'b0, payload_outbound}, 32'd0);
        check_eq({tag, "_count"},   {29'b0, fifo_count}, 32'd0);
        check_eq({tag, "_ready"},   {31'b0, ob_ready_to_recv}, 32'd1);
        check_eq({tag, "_err"},     {31'b0, overflow_err}, 32'd0);
    endtask

    initial begin
        int run;
        bit done;

        reset         = 1'b1;
        free_outbound = 1'b0;
        pkt_in_avail  = 1'b0;
        pkt_in        = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_reset_state("rst0");
        mon_en = 1'b1;

        // Single packet: put high at t+2..t+5.
        free_outbound = 1'b1;
        push_pkt(32'h1A2B3C4D, 1'b1);
        check_eq("lat_t1_put", {31'b0, put_outbound}, 32'd0);
        wait_cycles(1);
        check_eq("lat_t2_put", {31'b0, put_outbound}, 32'd1);
        wait_drain();

        // Fill to DEPTH, then one dropped packet.
        free_outbound = 1'b0;
        push_pkt(32'h11223344, 1'b1);
        push_pkt(32'h55667788, 1'b1);
        push_pkt(32'h99AABBCC, 1'b1);
        push_pkt(32'hDDEEFF01, 1'b1);
        check_eq("fill_count", {29'b0, fifo_count}, 32'd4);
        check_eq("fill_ready", {31'b0, ob_ready_to_recv}, 32'd0);
        check_eq("fill_err",   {31'b0, overflow_err}, 32'd0);
        push_pkt(32'hDEADBEEF, 1'b0);
        check_eq("ovf_err",    {31'b0, overflow_err}, 32'd1);
        check_eq("ovf_count",  {29'b0, fifo_count}, 32'd4);

        // Back-to-back: 4 queued packets give 16 consecutive put cycles.
        free_outbound = 1'b1;
        wait_put();
        run  = 1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (put_outbound) run++;
            else              done = 1'b1;
        end
        check_eq("b2b_run",   run, 32'd16);
        check_eq("b2b_count", {29'b0, fifo_count}, 32'd0);

        // Reset mid-packet with one more queued: transfer aborted, FIFO emptied.
        push_pkt(32'hCAFEF00D, 1'b1);
        push_pkt(32'h0BADC0DE, 1'b1);
        check_eq("mid_count", {29'b0, fifo_count}, 32'd1);
        check_eq("mid_put",   {31'b0, put_outbound}, 32'd1);
        mon_en = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        sb.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_reset_state("rst1");
        mon_en = 1'b1;
        repeat (8) @(negedge clock);

        // Push and pop in the same cycle at count 2.
        free_outbound = 1'b0;
        push_pkt(32'hA0A1A2A3, 1'b1);
        push_pkt(32'hB0B1B2B3, 1'b1);
        check_eq("pp_pre_count", {29'b0, fifo_count}, 32'd2);
        @(posedge clock); #1;
        free_outbound = 1'b1;
        pkt_in        = 32'hD0D1D2D3;
        pkt_in_avail  = 1'b1;
        sb_add(32'hD0D1D2D3);
        @(posedge clock); #1;
        pkt_in_avail  = 1'b0;
        free_outbound = 1'b0;
        check_eq("pp_count", {29'b0, fifo_count}, 32'd2);
        wait_cycles(6);
        push_pkt(32'hE0E1E2E3, 1'b1);
        push_pkt(32'hF0F1F2F3, 1'b1);
        check_eq("full_count", {29'b0, fifo_count}, 32'd4);
        check_eq("full_ready", {31'b0, ob_ready_to_recv}, 32'd0);
        // Push at full while popping is still rejected.
        @(posedge clock); #1;
        free_outbound = 1'b1;
        pkt_in        = 32'h99999999;
        pkt_in_avail  = 1'b1;
        @(posedge clock); #1;
        pkt_in_avail  = 1'b0;
        check_eq("fullpop_count", {29'b0, fifo_count}, 32'd3);
        check_eq("fullpop_err",   {31'b0, overflow_err}, 32'd1);
        check_eq("fullpop_ready", {31'b0, ob_ready_to_recv}, 32'd1);
        wait_drain();

        // free_outbound drops after the first byte: packet completes, next one waits.
        push_pkt(32'h61626364, 1'b1);
        wait_put();
        free_outbound = 1'b0;
        pkt_in        = 32'h71727374;
        pkt_in_avail  = 1'b1;
        sb_add(32'h71727374);
        @(posedge clock); #1;
        pkt_in_avail  = 1'b0;
        wait_cycles(6);
        check_eq("hold_put",   {31'b0, put_outbound}, 32'd0);
        check_eq("hold_count", {29'b0, fifo_count}, 32'd1);
        check_eq("hold_sb",    sb.size(), 32'd4);
        free_outbound = 1'b1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
